// File: rtl/mips150_mem_responder.sv
// MIPS150 memory-side responder: captures icache/dcache requests and
// serialises them (data first) onto one backing-memory handshake.
module mips150_mem_responder #(
    parameter int MEM_AW = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       icache_addr,
    input  logic              icache_re,
    input  logic [3:0]        icache_we,
    input  logic [31:0]       icache_din,
    input  logic [31:0]       dcache_addr,
    input  logic              dcache_re,
    input  logic [3:0]        dcache_we,
    input  logic [31:0]       dcache_din,
    output logic [31:0]       instruction,
    output logic [31:0]       dcache_dout,
    output logic              stall,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       stall_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_D_REQ = 2'd1,
        S_I_REQ = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_i_pend;
    logic [MEM_AW-1:0]   r_d_addr;
    logic [3:0]          r_d_we;
    logic [31:0]         r_d_din;
    logic [MEM_AW-1:0]   r_i_addr;
    logic [3:0]          r_i_we;
    logic [31:0]         r_i_din;
    logic [31:0]         r_instruction;
    logic [31:0]         r_dcache_dout;
    logic [31:0]         r_stall_count;
    logic                w_d_hit;
    logic                w_i_hit;
    logic                w_unused;

    // addr[31] selects IO space, which never reaches backing memory
    assign w_d_hit = ~dcache_addr[31] & (dcache_re | (|dcache_we));
    assign w_i_hit = ~icache_addr[31] & (icache_re | (|icache_we));
    assign w_unused = ^{icache_addr, dcache_addr};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_d_hit)
                    w_next = S_D_REQ;
                else if (w_i_hit)
                    w_next = S_I_REQ;
            end
            S_D_REQ: begin
                if (mem_ack)
                    w_next = r_i_pend ? S_I_REQ : S_IDLE;
            end
            S_I_REQ: begin
                if (mem_ack)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        unique case (r_state)
            S_D_REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_d_we;
                mem_addr  = r_d_addr;
                mem_wdata = r_d_din;
            end
            S_I_REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_i_we;
                mem_addr  = r_i_addr;
                mem_wdata = r_i_din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_i_pend      <= 1'b0;
            r_d_addr      <= '0;
            r_d_we        <= 4'd0;
            r_d_din       <= 32'd0;
            r_i_addr      <= '0;
            r_i_we        <= 4'd0;
            r_i_din       <= 32'd0;
            r_instruction <= 32'd0;
            r_dcache_dout <= 32'd0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    r_i_pend <= w_i_hit;
                    if (w_d_hit) begin
                        r_d_addr <= dcache_addr[MEM_AW+1:2];
                        r_d_we   <= dcache_we;
                        r_d_din  <= dcache_din;
                    end
                    if (w_i_hit) begin
                        r_i_addr <= icache_addr[MEM_AW+1:2];
                        r_i_we   <= icache_we;
                        r_i_din  <= icache_din;
                    end
                end
                S_D_REQ: begin
                    if (mem_ack && r_d_we == 4'd0)
                        r_dcache_dout <= mem_rdata;
                end
                S_I_REQ: begin
                    if (mem_ack) begin
                        r_i_pend <= 1'b0;
                        if (r_i_we == 4'd0)
                            r_instruction <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_count <= 32'd0;
        else if (r_state != S_IDLE)
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall       = (r_state != S_IDLE);
    assign instruction = r_instruction;
    assign dcache_dout = r_dcache_dout;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_mips150_mem_responder.sv
// Directed bench for mips150_mem_responder.
module tb_mips150_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [3:0]  icache_we;
    logic [31:0] icache_din;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] instruction;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [25:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] stall_count;

    int ncmp = 0;
    int nfail = 0;

    mips150_mem_responder #(.MEM_AW(26)) dut (
        .clk(clk), .rst(rst),
        .icache_addr(icache_addr), .icache_re(icache_re),
        .icache_we(icache_we), .icache_din(icache_din),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re),
        .dcache_we(dcache_we), .dcache_din(dcache_din),
        .instruction(instruction), .dcache_dout(dcache_dout),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] wrap_exp [3];
        wrap_exp[0] = 32'hFFFF_FFFF;
        wrap_exp[1] = 32'h0000_0000;
        wrap_exp[2] = 32'h0000_0001;

        rst = 1'b0;
        icache_addr = 0; icache_re = 0; icache_we = 0; icache_din = 0;
        dcache_addr = 0; dcache_re = 0; dcache_we = 0; dcache_din = 0;
        mem_ack = 0; mem_rdata = 0;

        // reset
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_dout", dcache_dout, 32'd0);
        chk("rst_cnt", stall_count, 32'd0);

        // fetch only, ack after 3 stall cycles
        icache_re = 1; icache_addr = 32'h40;
        @(negedge clk);
        icache_re = 0; icache_addr = 32'h999;
        chk("f_stall1", 32'(stall), 32'd1);
        chk("f_req", 32'(mem_req), 32'd1);
        chk("f_addr", 32'(mem_addr), 32'h10);
        chk("f_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("f_stall2", 32'(stall), 32'd1);
        chk("f_addr2", 32'(mem_addr), 32'h10);
        @(negedge clk);
        chk("f_stall3", 32'(stall), 32'd1);
        mem_ack = 1; mem_rdata = 32'h2408_0005;
        @(negedge clk);
        mem_ack = 0;
        chk("f_stall_end", 32'(stall), 32'd0);
        chk("f_req_end", 32'(mem_req), 32'd0);
        chk("f_instr", instruction, 32'h2408_0005);
        chk("f_cnt", stall_count, 32'd3);

        // simultaneous D write + I read, zero-wait
        dcache_we = 4'b0011; dcache_addr = 32'h100;
        dcache_din = 32'hDEAD_BEEF;
        icache_re = 1; icache_addr = 32'h44;
        @(negedge clk);
        dcache_we = 0; dcache_addr = 0; dcache_din = 0;
        icache_re = 0; icache_addr = 0;
        chk("s_d_req", 32'(mem_req), 32'd1);
        chk("s_d_we", 32'(mem_we), 32'h3);
        chk("s_d_addr", 32'(mem_addr), 32'h40);
        chk("s_d_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s_d_stall", 32'(stall), 32'd1);
        mem_ack = 1; mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        chk("s_i_req", 32'(mem_req), 32'd1);
        chk("s_i_we", 32'(mem_we), 32'd0);
        chk("s_i_addr", 32'(mem_addr), 32'h11);
        chk("s_i_stall", 32'(stall), 32'd1);
        mem_rdata = 32'h0C00_0010;
        @(negedge clk);
        mem_ack = 0;
        chk("s_stall_end", 32'(stall), 32'd0);
        chk("s_dout", dcache_dout, 32'd0);
        chk("s_instr", instruction, 32'h0C00_0010);
        chk("s_cnt", stall_count, 32'd5);

        // data read, zero-wait
        dcache_re = 1; dcache_addr = 32'h200;
        @(negedge clk);
        dcache_re = 0; dcache_addr = 0;
        chk("r_addr", 32'(mem_addr), 32'h80);
        chk("r_we", 32'(mem_we), 32'd0);
        chk("r_stall", 32'(stall), 32'd1);
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 0;
        chk("r_stall_end", 32'(stall), 32'd0);
        chk("r_dout", dcache_dout, 32'hCAFE_F00D);
        chk("r_instr", instruction, 32'h0C00_0010);
        chk("r_cnt", stall_count, 32'd6);

        // IO bypass
        dcache_re = 1; dcache_addr = 32'h8000_0004;
        @(negedge clk);
        chk("io_stall", 32'(stall), 32'd0);
        chk("io_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("io_stall2", 32'(stall), 32'd0);
        chk("io_cnt", stall_count, 32'd6);
        dcache_re = 0; dcache_addr = 0;
        @(negedge clk);

        // counter wrap
        force dut.r_stall_count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_stall_count;
        @(negedge clk);
        chk("w_preload", stall_count, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            icache_re = 1; icache_addr = 32'h8;
            @(negedge clk);
            icache_re = 0; icache_addr = 0;
            mem_ack = 1; mem_rdata = 32'h100 + 32'(i);
            @(negedge clk);
            mem_ack = 0;
            chk("w_cnt", stall_count, wrap_exp[i]);
            chk("w_instr", instruction, 32'h100 + 32'(i));
        end

        // reset mid-transaction
        dcache_re = 1; dcache_addr = 32'h300;
        @(negedge clk);
        dcache_re = 0; dcache_addr = 0;
        chk("m_req", 32'(mem_req), 32'd1);
        chk("m_addr", 32'(mem_addr), 32'hC0);
        #2 rst = 1'b0;
        #1;
        chk("m_req_drop", 32'(mem_req), 32'd0);
        chk("m_stall_drop", 32'(stall), 32'd0);
        chk("m_addr_drop", 32'(mem_addr), 32'd0);
        chk("m_dout_rst", dcache_dout, 32'd0);
        chk("m_cnt_rst", stall_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 0;
        chk("m_stale_dout", dcache_dout, 32'd0);
        chk("m_stale_instr", instruction, 32'd0);
        chk("m_stale_stall", 32'(stall), 32'd0);
        chk("m_stale_req", 32'(mem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
